// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the IF-to-ID fetch queue.
package if_pkg;

  localparam logic [31:2] START_ADDR    = 30'h0000BFF;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam int          DEPTH_DEFAULT = 2;

  // One fetched word together with the address it was read from.
  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Bundle of fetch-side and decode-side signals around the fetch queue.
interface if_fetch_queue_if #(
  parameter int DEPTH = if_pkg::DEPTH_DEFAULT
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:2]   PC;
  logic [31:0]   Instr;
  logic          Flush;
  logic          IDReady;
  logic          PCWrite;
  logic          IDValid;
  logic [31:2]   IDPC;
  logic [31:0]   IDInstr;
  logic [CW-1:0] Count;
  logic [31:0]   FetchCnt;
  logic [31:0]   StallCnt;

  // Environment side: PC register, instruction memory, EX redirect, ID stage.
  modport master (
    output PC, Instr, Flush, IDReady,
    input  PCWrite, IDValid, IDPC, IDInstr, Count, FetchCnt, StallCnt
  );

  // Queue side.
  modport slave (
    input  PC, Instr, Flush, IDReady,
    output PCWrite, IDValid, IDPC, IDInstr, Count, FetchCnt, StallCnt
  );

endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Circular buffer of fetch entries with push, pop and synchronous clear.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = if_pkg::DEPTH_DEFAULT,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t wr_data_i,
  output fetch_entry_t rd_data_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset discards every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch queue between IF and ID: PCWrite back-pressure, redirect flush,
// empty-head masking and fetch/stall statistics.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int          DEPTH     = if_pkg::DEPTH_DEFAULT,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  if_fetch_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          push, pop, full, empty, pc_write;
  logic [CW-1:0] count;
  fetch_entry_t  head, tail_entry;
  logic [31:0]   fetch_cnt_q, fetch_cnt_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // A redirect always lets the PC take the target; otherwise advance when a slot is free.
  assign pop      = !empty & bus.IDReady & !bus.Flush;
  assign pc_write = bus.Flush | !full | pop;
  assign push     = pc_write & !bus.Flush;

  assign tail_entry.pc    = bus.PC;
  assign tail_entry.instr = bus.Instr;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (pop),
    .clear_i   (bus.Flush),
    .wr_data_i (tail_entry),
    .rd_data_o (head),
    .count_o   (count)
  );

  // Statistics next-state; both counters wrap at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push)      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (!pc_write) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.PCWrite  = pc_write;
  assign bus.IDValid  = !empty;
  assign bus.IDPC     = empty ? 30'd0 : head.pc;
  assign bus.IDInstr  = empty ? NOP_INSTR : head.instr;
  assign bus.Count    = count;
  assign bus.FetchCnt = fetch_cnt_q;
  assign bus.StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue (DEPTH=2).
module tb_if_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  if_fetch_queue_if #(.DEPTH(2)) bus();

  if_fetch_queue #(
    .DEPTH     (2),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] instr_of(input logic [31:2] pc);
    return {pc, 2'b11} ^ 32'hDEAD_0000;
  endfunction

  // Instruction memory: read data for the current PC in the same cycle.
  assign bus.Instr = instr_of(bus.PC);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.Flush   = 1'b0;
    bus.IDReady = 1'b0;
    bus.PC      = 30'h0000BFF;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.Count !== 2'd0) begin fails++; $display("FAIL reset_count act=%0d exp=0", bus.Count); end
    tests++; if (bus.IDValid !== 1'b0) begin fails++; $display("FAIL reset_idvalid act=%b exp=0", bus.IDValid); end
    tests++; if (bus.IDPC !== 30'd0) begin fails++; $display("FAIL reset_idpc act=%h exp=0", bus.IDPC); end
    tests++; if (bus.IDInstr !== NOP) begin fails++; $display("FAIL reset_idinstr act=%h exp=%h", bus.IDInstr, NOP); end
    tests++; if (bus.FetchCnt !== 32'd0) begin fails++; $display("FAIL reset_fetchcnt act=%0d exp=0", bus.FetchCnt); end
    tests++; if (bus.StallCnt !== 32'd0) begin fails++; $display("FAIL reset_stallcnt act=%0d exp=0", bus.StallCnt); end
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL reset_pcwrite act=%b exp=1", bus.PCWrite); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.IDReady = 1'b1;
    #1;
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL stream_pcw0 act=%b exp=1", bus.PCWrite); end
    tick();
    bus.PC = 30'h0000C00;
    #1;
    tests++; if (bus.IDPC !== 30'h0000BFF) begin fails++; $display("FAIL stream_idpc0 act=%h exp=0000bff", bus.IDPC); end
    tests++; if (bus.Count !== 2'd1) begin fails++; $display("FAIL stream_count0 act=%0d exp=1", bus.Count); end
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL stream_pcw1 act=%b exp=1", bus.PCWrite); end
    tests++; if (bus.IDInstr !== 32'hDEAD_2FFF) begin fails++; $display("FAIL stream_instr0 act=%h exp=dead2fff", bus.IDInstr); end
    tick();
    bus.PC = 30'h0000C01;
    #1;
    tests++; if (bus.IDPC !== 30'h0000C00) begin fails++; $display("FAIL stream_idpc1 act=%h exp=0000c00", bus.IDPC); end
    tests++; if (bus.Count !== 2'd1) begin fails++; $display("FAIL stream_count1 act=%0d exp=1", bus.Count); end
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL stream_pcw2 act=%b exp=1", bus.PCWrite); end
    tick();
    tests++; if (bus.IDPC !== 30'h0000C01) begin fails++; $display("FAIL stream_idpc2 act=%h exp=0000c01", bus.IDPC); end
    tests++; if (bus.FetchCnt !== 32'd3) begin fails++; $display("FAIL stream_fetchcnt act=%0d exp=3", bus.FetchCnt); end
    tests++; if (bus.StallCnt !== 32'd0) begin fails++; $display("FAIL stream_stallcnt act=%0d exp=0", bus.StallCnt); end
  endtask

  // Leaves the queue full with 0BFF, 0C00 and PC held at 0C01.
  task automatic test_stall();
    do_reset();
    bus.IDReady = 1'b0;
    #1;
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL stall_pcw1 act=%b exp=1", bus.PCWrite); end
    tick();
    bus.PC = 30'h0000C00;
    #1;
    tests++; if (bus.Count !== 2'd1) begin fails++; $display("FAIL stall_count1 act=%0d exp=1", bus.Count); end
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL stall_pcw2 act=%b exp=1", bus.PCWrite); end
    tick();
    bus.PC = 30'h0000C01;
    #1;
    tests++; if (bus.Count !== 2'd2) begin fails++; $display("FAIL stall_count2 act=%0d exp=2", bus.Count); end
    tests++; if (bus.PCWrite !== 1'b0) begin fails++; $display("FAIL stall_pcw3 act=%b exp=0", bus.PCWrite); end
    for (int i = 0; i < 4; i++) tick();
    tests++; if (bus.StallCnt !== 32'd4) begin fails++; $display("FAIL stall_stallcnt act=%0d exp=4", bus.StallCnt); end
    tests++; if (bus.IDPC !== 30'h0000BFF) begin fails++; $display("FAIL stall_idpc act=%h exp=0000bff", bus.IDPC); end
    tests++; if (bus.Count !== 2'd2) begin fails++; $display("FAIL stall_count_hold act=%0d exp=2", bus.Count); end
    tests++; if (bus.FetchCnt !== 32'd2) begin fails++; $display("FAIL stall_fetchcnt act=%0d exp=2", bus.FetchCnt); end
    tests++; if (bus.PCWrite !== 1'b0) begin fails++; $display("FAIL stall_pcw_hold act=%b exp=0", bus.PCWrite); end
  endtask

  task automatic test_full_pop();
    bus.IDReady = 1'b1;
    #1;
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL fullpop_pcw act=%b exp=1", bus.PCWrite); end
    tick();
    bus.IDReady = 1'b0;
    bus.PC      = 30'h0000C02;
    #1;
    tests++; if (bus.Count !== 2'd2) begin fails++; $display("FAIL fullpop_count act=%0d exp=2", bus.Count); end
    tests++; if (bus.IDPC !== 30'h0000C00) begin fails++; $display("FAIL fullpop_idpc act=%h exp=0000c00", bus.IDPC); end
    tests++; if (bus.FetchCnt !== 32'd3) begin fails++; $display("FAIL fullpop_fetchcnt act=%0d exp=3", bus.FetchCnt); end
    tests++; if (bus.StallCnt !== 32'd4) begin fails++; $display("FAIL fullpop_stallcnt act=%0d exp=4", bus.StallCnt); end
    tests++; if (bus.PCWrite !== 1'b0) begin fails++; $display("FAIL fullpop_pcw_after act=%b exp=0", bus.PCWrite); end
  endtask

  task automatic test_flush();
    bus.IDReady = 1'b1;
    bus.Flush   = 1'b1;
    #1;
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL flush_pcw act=%b exp=1", bus.PCWrite); end
    tick();
    bus.Flush   = 1'b0;
    bus.IDReady = 1'b0;
    bus.PC      = 30'h0000100;
    #1;
    tests++; if (bus.Count !== 2'd0) begin fails++; $display("FAIL flush_count act=%0d exp=0", bus.Count); end
    tests++; if (bus.IDValid !== 1'b0) begin fails++; $display("FAIL flush_idvalid act=%b exp=0", bus.IDValid); end
    tests++; if (bus.IDInstr !== NOP) begin fails++; $display("FAIL flush_idinstr act=%h exp=%h", bus.IDInstr, NOP); end
    tests++; if (bus.IDPC !== 30'd0) begin fails++; $display("FAIL flush_idpc act=%h exp=0", bus.IDPC); end
    tests++; if (bus.FetchCnt !== 32'd3) begin fails++; $display("FAIL flush_fetchcnt act=%0d exp=3", bus.FetchCnt); end
    tick();
    tests++; if (bus.IDPC !== 30'h0000100) begin fails++; $display("FAIL flush_target_idpc act=%h exp=0000100", bus.IDPC); end
    tests++; if (bus.Count !== 2'd1) begin fails++; $display("FAIL flush_target_count act=%0d exp=1", bus.Count); end
    tests++; if (bus.FetchCnt !== 32'd4) begin fails++; $display("FAIL flush_target_fetchcnt act=%0d exp=4", bus.FetchCnt); end
  endtask

  task automatic test_wrap();
    logic        rdy_v [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        pcw_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0]  cnt_v [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    logic [31:2] pc_v  [6] = '{30'h0, 30'h200, 30'h201, 30'h201, 30'h202, 30'h202};
    logic        pcw;
    do_reset();
    bus.PC = 30'h0000200;
    for (int i = 0; i < 6; i++) begin
      bus.IDReady = rdy_v[i];
      #1;
      pcw = bus.PCWrite;
      tests++; if (bus.PCWrite !== pcw_v[i]) begin fails++; $display("FAIL wrap_pcw[%0d] act=%b exp=%b", i, bus.PCWrite, pcw_v[i]); end
      tests++; if (bus.Count !== cnt_v[i]) begin fails++; $display("FAIL wrap_count[%0d] act=%0d exp=%0d", i, bus.Count, cnt_v[i]); end
      tests++; if (bus.IDPC !== pc_v[i]) begin fails++; $display("FAIL wrap_idpc[%0d] act=%h exp=%h", i, bus.IDPC, pc_v[i]); end
      tick();
      if (pcw) bus.PC = bus.PC + 30'd1;
    end
    bus.IDReady = 1'b0;
    #1;
    tests++; if (bus.IDPC !== 30'h0000203) begin fails++; $display("FAIL wrap_final_idpc act=%h exp=0000203", bus.IDPC); end
    tests++; if (bus.IDInstr !== instr_of(30'h0000203)) begin fails++; $display("FAIL wrap_final_instr act=%h exp=%h", bus.IDInstr, instr_of(30'h0000203)); end
    tests++; if (bus.Count !== 2'd2) begin fails++; $display("FAIL wrap_final_count act=%0d exp=2", bus.Count); end
    tests++; if (bus.FetchCnt !== 32'd5) begin fails++; $display("FAIL wrap_final_fetchcnt act=%0d exp=5", bus.FetchCnt); end
    tests++; if (bus.StallCnt !== 32'd1) begin fails++; $display("FAIL wrap_final_stallcnt act=%0d exp=1", bus.StallCnt); end
    bus.IDReady = 1'b1;
    tick();
    tests++; if (bus.IDPC !== 30'h0000204) begin fails++; $display("FAIL wrap_tail_idpc act=%h exp=0000204", bus.IDPC); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    tick();
    tests++; if (bus.Count !== 2'd2) begin fails++; $display("FAIL rmid_prefill act=%0d exp=2", bus.Count); end
    reset       = 1'b1;
    bus.Flush   = 1'b1;
    bus.IDReady = 1'b1;
    tick();
    bus.Flush   = 1'b0;
    bus.IDReady = 1'b0;
    #1;
    tests++; if (bus.Count !== 2'd0) begin fails++; $display("FAIL rmid_count act=%0d exp=0", bus.Count); end
    tests++; if (bus.IDValid !== 1'b0) begin fails++; $display("FAIL rmid_idvalid act=%b exp=0", bus.IDValid); end
    tests++; if (bus.IDPC !== 30'd0) begin fails++; $display("FAIL rmid_idpc act=%h exp=0", bus.IDPC); end
    tests++; if (bus.IDInstr !== NOP) begin fails++; $display("FAIL rmid_idinstr act=%h exp=%h", bus.IDInstr, NOP); end
    tests++; if (bus.FetchCnt !== 32'd0) begin fails++; $display("FAIL rmid_fetchcnt act=%0d exp=0", bus.FetchCnt); end
    tests++; if (bus.StallCnt !== 32'd0) begin fails++; $display("FAIL rmid_stallcnt act=%0d exp=0", bus.StallCnt); end
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL rmid_pcwrite act=%b exp=1", bus.PCWrite); end
    reset = 1'b0;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset       = 1'b1;
    bus.Flush   = 1'b0;
    bus.IDReady = 1'b0;
    bus.PC      = 30'h0000BFF;
    test_reset();
    test_stream();
    test_stall();
    test_full_pop();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Decoupling queue between the IF stage program counter and the ID stage. Each cycle it captures the current fetch address and the instruction read at that address into a small FIFO. It presents the oldest entry to ID and drives `PCWrite` back to the PC register, so fetch advances only when there is room. It also discards everything on a branch/jump redirect and keeps fetch/stall statistics counters.

## Interface
- `DEPTH`, 2: entry count; power of two, ≥2
- `NOP_INSTR`, 32'h0000_0000: value driven on `IDInstr` when the queue is empty
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`
- `PC`  in  30 [31:2]  current fetch address from the PC register
- `Instr`  in  32  instruction memory read data for `PC`, valid in the same cycle
- `Flush`  in  1  redirect from EX; PC loads branch/jump target this cycle
- `IDReady`  in  1  ID consumes the head entry this cycle
- `PCWrite`  out  1  to PC register: load NPC at next edge
- `IDValid`  out  1  head entry valid
- `IDPC`  out  30 [31:2]  head entry address
- `IDInstr`  out  32  head entry instruction
- `Count`  out  $clog2(DEPTH)+1  occupied entries
- `FetchCnt`  out  32  total entries enqueued since reset
- `StallCnt`  out  32  cycles with `PCWrite`=0 since reset

## Operation
- `pop = IDValid & IDReady & !Flush`.
- `full = (Count == DEPTH)`.
- `PCWrite = Flush | !full | pop`, combinational from current state and inputs.
- `push = PCWrite & !Flush`: writes `{PC, Instr}` at the tail.
- On `Flush`:
  - clear count and both pointers; the head is discarded even if `IDReady`=1;
  - the wrong-path word at `PC` is not enqueued;
  - `PCWrite`=1 so the PC register takes the redirect target.
- Push and pop in the same cycle: count unchanged. Legal when full only because `pop` frees a slot.
- Pop when empty cannot occur, because `IDValid`=0 forces `pop`=0. A push into an empty queue becomes the head next cycle.
- Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- `IDValid = (Count != 0)`.
- Head outputs come from registered storage at the read pointer. When the queue is empty, `IDPC`=0 and `IDInstr`=`NOP_INSTR`.
- `FetchCnt` increments on `push`. `StallCnt` increments when `PCWrite`=0. Both wrap at 2^32.
- Reset values:
  - `Count`=0, pointers 0, `IDValid`=0, `IDPC`=0, `IDInstr`=`NOP_INSTR`;
  - `FetchCnt`=0, `StallCnt`=0;
  - `PCWrite`=1 after reset, since the queue is empty.
- `reset` overrides `Flush`, `IDReady` and any in-flight push.

## Timing
- Fetch-to-decode latency is 1 cycle: an entry pushed at edge N is on `IDPC`/`IDInstr` with `IDValid`=1 after edge N.
- Back-pressure: when full and `IDReady`=0, `PCWrite`=0 in that same cycle. PC holds, and `Instr` for the held `PC` is re-presented next cycle.
- The same-cycle `IDReady` → `PCWrite` path is combinational. It is the only combinational path from an input to an output other than `Flush`.
- The redirect takes 1 cycle: after a `Flush` edge, the queue is empty. The first target instruction can be pushed in the following cycle and is visible to ID one cycle later.
- Reset asserted mid-operation: all entries are lost at that edge and nothing is pushed that cycle.
- Entries are never reordered or duplicated. Each `{PC, Instr}` pushed is popped exactly once or flushed.

## Structure
- Shared package `if_pkg`:
  - `START_ADDR` (30'h0000BFF);
  - `NOP_INSTR`;
  - default `DEPTH`;
  - `typedef struct packed {logic [31:2] pc; logic [31:0] instr;} fetch_entry_t`.
- Sub-module `fetch_fifo`: storage array of `fetch_entry_t`, pointers and count, with push/pop/clear inputs.
- The top level holds the `PCWrite`/`push`/`pop` logic, empty-output masking and the statistics counters.

## Test plan
- Reset, then `IDReady`=1 steady with `PC` stepping 0BFF, 0C00, 0C01 → `IDPC` follows one cycle behind, `Count`=1, `PCWrite`=1 every cycle, `FetchCnt`=3 after 3 cycles.
- `IDReady`=0 from reset → `Count` goes 1, 2; `PCWrite`=0 from cycle 3 on. After 4 stalled cycles, `StallCnt`=4 and `IDPC`=0BFF still held.
- Full queue with `IDReady`=1 for one cycle → pop of 0BFF and push of the held `PC` in the same edge. `Count` stays 2, and the head becomes 0C00.
- `Flush` with `Count`=2 and `IDReady`=1 → next cycle `Count`=0, `IDValid`=0, `IDInstr`=`NOP_INSTR`, `FetchCnt` unchanged. `PCWrite`=1 during the flush cycle.
- Push 5 entries through with alternating `IDReady` → pointer wrap, in-order `IDPC` sequence, no loss or duplicate.
- `reset` asserted with `Count`=2 and `Flush`=1 → all outputs at reset values at the next edge.
